// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush sequencer for the 5-stage pipeline.  It looks at the
// hazard flag, the instruction/data memory ready handshakes, the jump opcode
// in decode and a halt request.  It then drives the per-stage load enables,
// the ID/EX bubble, the IF/ID flush and the halt-drain handshake.  It also
// keeps two saturating performance counters and a sticky memory-timeout flag.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   is_hazard      data hazard between decode and EX/MEM/WB
//   opcode_step_2  opcode in decode (6'b000010 = j)
//   opcode_step_4  opcode in memory stage (6'b100011 = lw, 6'b101011 = sw)
//   imem_ready     instruction memory returns valid data this cycle
//   dmem_ready     data memory completes its access this cycle
//   halt_req       level request to stop fetch and drain the pipe
//   pc_we, if_id_we, ex_mem_we, mem_wb_we   per-stage load enables
//   if_id_flush    load NOP into IF/ID (meaningful only with if_id_we=1)
//   id_ex_bubble   load NOP into ID/EX
//   halted         drain finished, pipeline empty (registered)
//   mem_timeout    sticky: a MEMWAIT run reached MEM_TIMEOUT cycles
//   state          RUN=0, STALL=1, MEMWAIT=2, HALT=3
//   stall_cnt      cycles with pc_we=0 outside HALT (saturating)
//   flush_cnt      jump flushes issued (saturating)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255,
   parameter int DRAIN_CYC   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             is_hazard,
   input  logic [5:0]       opcode_step_2,
   input  logic [5:0]       opcode_step_4,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             halt_req,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             halted,
   output logic             mem_timeout,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
   localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_CYC);
   localparam logic [5:0] OP_J  = 6'b000010;
   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_STALL   = 2'd1,
      S_MEMWAIT = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   state_t               cur_st, nxt_st;
   logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;
   logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
   logic                 halted_q, timeout_q;
   logic [CNT_W-1:0]     stall_q, flush_q;

   logic memop, dfreeze, ifstall, jmp, hold, flush_fire;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
      return (v == WAIT_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [DRAIN_W-1:0] sat_inc_drain(input logic [DRAIN_W-1:0] v);
      return (v == DRAIN_MAX) ? v : v + 1'b1;
   endfunction

   assign memop   = (opcode_step_4 == OP_LW) || (opcode_step_4 == OP_SW);
   assign dfreeze = memop && !dmem_ready;
   assign ifstall = !imem_ready;
   assign jmp     = (opcode_step_2 == OP_J);
   assign hold    = is_hazard || ifstall;

   // A jump flush only fires when nothing of higher priority claims the cycle.
   // Jumps are ignored while halting.
   assign flush_fire = (cur_st != S_HALT) && !dfreeze && !hold && jmp;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cur_st <= S_RUN;
      else      cur_st <= nxt_st;
   end

   // Next-state logic (drain counter follows the same decision tree)
   always_comb begin
      nxt_st    = cur_st;
      drain_nxt = drain_cnt;
      if (cur_st == S_HALT) begin
         // A data-memory freeze pins HALT in place, drain progress included.
         if (!dfreeze) begin
            if (!halt_req) begin
               nxt_st    = S_RUN;
               drain_nxt = '0;
            end else begin
               drain_nxt = sat_inc_drain(drain_cnt);
            end
         end
      end else if (dfreeze) begin
         nxt_st = S_MEMWAIT;
      end else if (hold) begin
         nxt_st = S_STALL;
      end else if (jmp) begin
         nxt_st = S_RUN;
      end else if (halt_req) begin
         nxt_st    = S_HALT;
         drain_nxt = '0;
      end else begin
         nxt_st = S_RUN;
      end
   end

   // The wait counter counts only while MEMWAIT persists.
   // Any exit clears it.
   assign wait_nxt = (cur_st == S_MEMWAIT && dfreeze) ? sat_inc_wait(wait_cnt) : '0;

   // Output logic
   always_comb begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      // While reset is held the controls sit at their idle values.
      // This holds regardless of the inputs.
      if (rst) begin
         if (dfreeze) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
         end else if (cur_st == S_HALT) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
         end else if (hold) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
         end else if (jmp) begin
            if_id_flush = 1'b1;
         end else if (halt_req) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
         end
      end
   end

   // Counters, drain handshake and sticky timeout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain_cnt <= '0;
         wait_cnt  <= '0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         drain_cnt <= drain_nxt;
         wait_cnt  <= wait_nxt;
         halted_q  <= (nxt_st == S_HALT) && (drain_nxt == DRAIN_MAX);
         if (cur_st == S_MEMWAIT && dfreeze && wait_nxt == WAIT_MAX)
            timeout_q <= 1'b1;
         if (!pc_we && cur_st != S_HALT)
            stall_q <= sat_inc_cnt(stall_q);
         if (flush_fire)
            flush_q <= sat_inc_cnt(flush_q);
      end
   end

   assign state       = cur_st;
   assign halted      = halted_q;
   assign mem_timeout = timeout_q;
   assign stall_cnt   = stall_q;
   assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Self-checking bench for pipe_stall_ctrl (CNT_W=4 build so saturation is
// reachable quickly).  It runs a directed vector table first.  Hand-written
// sequences follow for MEMWAIT timeout, halt/drain and asynchronous reset.
// Randomized traffic then runs against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 255;
   localparam int DRAIN_CYC   = 3;
   localparam int CMAX        = (1 << CNT_W) - 1;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_NOP = 6'b001000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic is_hazard = 1'b0;
   logic [5:0] opcode_step_2 = OP_NOP;
   logic [5:0] opcode_step_4 = OP_NOP;
   logic imem_ready = 1'b1;
   logic dmem_ready = 1'b1;
   logic halt_req = 1'b0;
   logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we;
   logic halted, mem_timeout;
   logic [1:0] state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst(rst), .is_hazard(is_hazard),
      .opcode_step_2(opcode_step_2), .opcode_step_4(opcode_step_4),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt_req(halt_req),
      .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
      .halted(halted), .mem_timeout(mem_timeout), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode numbers follow the externally visible state code.
   int m_st, m_drain, m_wait, m_stall, m_flush;
   bit m_halted, m_tmo, m_dfz;
   bit e_pc, e_ifid, e_fl, e_bub, e_exm, e_mwb;

   task automatic model_reset();
      m_st = 0; m_drain = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      m_halted = 0; m_tmo = 0;
   endtask

   function automatic void model_outputs();
      bit mem_op;
      mem_op = (opcode_step_4 == OP_LW) || (opcode_step_4 == OP_SW);
      m_dfz  = mem_op && !dmem_ready;
      {e_pc, e_ifid, e_fl, e_bub, e_exm, e_mwb} = 6'b110011;
      if (m_dfz) begin
         {e_pc, e_ifid, e_exm, e_mwb} = 4'b0000;
      end else if (m_st == 3) begin
         e_pc = 0; e_fl = 1;
      end else if (is_hazard || !imem_ready) begin
         e_pc = 0; e_ifid = 0; e_bub = 1;
      end else if (opcode_step_2 == OP_J) begin
         e_fl = 1;
      end else if (halt_req) begin
         e_pc = 0; e_fl = 1;
      end
   endfunction

   function automatic void model_clock();
      if (m_st == 3) begin
         if (!m_dfz) begin
            if (!halt_req) begin m_st = 0; m_drain = 0; end
            else if (m_drain < DRAIN_CYC) m_drain++;
         end
      end else begin
         if (!e_pc && m_stall < CMAX) m_stall++;
         if (m_dfz) begin
            if (m_st == 2) begin if (m_wait < MEM_TIMEOUT) m_wait++; end
            else m_wait = 0;
            m_st = 2;
            if (m_wait == MEM_TIMEOUT) m_tmo = 1;
         end else begin
            m_wait = 0;
            if (is_hazard || !imem_ready) m_st = 1;
            else if (opcode_step_2 == OP_J) begin
               m_st = 0;
               if (m_flush < CMAX) m_flush++;
            end else if (halt_req) begin m_st = 3; m_drain = 0; end
            else m_st = 0;
         end
      end
      m_halted = (m_st == 3) && (m_drain == DRAIN_CYC);
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".pc_we"}, pc_we, e_pc);
      check({tag, ".if_id_we"}, if_id_we, e_ifid);
      check({tag, ".if_id_flush"}, if_id_flush, e_fl);
      check({tag, ".id_ex_bubble"}, id_ex_bubble, e_bub);
      check({tag, ".ex_mem_we"}, ex_mem_we, e_exm);
      check({tag, ".mem_wb_we"}, mem_wb_we, e_mwb);
      check({tag, ".state"}, state, m_st);
      check({tag, ".halted"}, halted, m_halted);
      check({tag, ".mem_timeout"}, mem_timeout, m_tmo);
      check({tag, ".stall_cnt"}, stall_cnt, m_stall);
      check({tag, ".flush_cnt"}, flush_cnt, m_flush);
   endtask

   // ---------------- cycle helpers ----------------
   task automatic set_in(input logic hz, input logic [5:0] o2, input logic [5:0] o4,
                         input logic im, input logic dm, input logic hr);
      is_hazard = hz; opcode_step_2 = o2; opcode_step_4 = o4;
      imem_ready = im; dmem_ready = dm; halt_req = hr;
   endtask

   task automatic settle(input bit use_model, input string tag);
      #2;
      model_outputs();
      if (use_model) check_model(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".state"}, state, 0);
      check({tag, ".pc_we"}, pc_we, 1);
      check({tag, ".if_id_we"}, if_id_we, 1);
      check({tag, ".if_id_flush"}, if_id_flush, 0);
      check({tag, ".id_ex_bubble"}, id_ex_bubble, 0);
      check({tag, ".ex_mem_we"}, ex_mem_we, 1);
      check({tag, ".mem_wb_we"}, mem_wb_we, 1);
      check({tag, ".halted"}, halted, 0);
      check({tag, ".mem_timeout"}, mem_timeout, 0);
      check({tag, ".stall_cnt"}, stall_cnt, 0);
      check({tag, ".flush_cnt"}, flush_cnt, 0);
   endtask

   // Called at posedge+1: reset is asserted between edges, checked, then released.
   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      check_reset_vals(tag);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic       hz;
      logic [5:0] o2;
      logic [5:0] o4;
      logic       im, dm, hr;
      logic       pc, ifid, fl, bub, exm;
      logic [1:0] st;
      int         stall;
      int         flush;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0};
      tbl[1]  = '{1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0};
      tbl[2]  = '{1'b1, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 0, 0};
      tbl[3]  = '{1'b1, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1, 0};
      tbl[4]  = '{1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2, 0};
      tbl[5]  = '{1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2, 0};
      tbl[6]  = '{1'b0, OP_J,   OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2, 0};
      tbl[7]  = '{1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2, 1};
      tbl[8]  = '{1'b0, OP_J,   OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2, 1};
      tbl[9]  = '{1'b0, OP_J,   OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 3, 1};
      tbl[10] = '{1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3, 2};
      tbl[11] = '{1'b1, OP_J,   OP_SW,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3, 2};
      tbl[12] = '{1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4, 2};
      tbl[13] = '{1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4, 2};

      // Reset state at time 0
      #1;
      check_reset_vals("reset0");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Idle after reset: counters must stay at zero
      set_in(1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         settle(1, "idle");
         tick();
      end
      check("idle.stall_cnt", stall_cnt, 0);
      check("idle.flush_cnt", flush_cnt, 0);

      // Directed vector table
      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i].hz, tbl[i].o2, tbl[i].o4, tbl[i].im, tbl[i].dm, tbl[i].hr);
         settle(0, "");
         check($sformatf("tbl%0d.pc_we", i), pc_we, tbl[i].pc);
         check($sformatf("tbl%0d.if_id_we", i), if_id_we, tbl[i].ifid);
         check($sformatf("tbl%0d.if_id_flush", i), if_id_flush, tbl[i].fl);
         check($sformatf("tbl%0d.id_ex_bubble", i), id_ex_bubble, tbl[i].bub);
         check($sformatf("tbl%0d.ex_mem_we", i), ex_mem_we, tbl[i].exm);
         check($sformatf("tbl%0d.mem_wb_we", i), mem_wb_we, tbl[i].exm);
         check($sformatf("tbl%0d.state", i), state, tbl[i].st);
         check($sformatf("tbl%0d.stall_cnt", i), stall_cnt, tbl[i].stall);
         check($sformatf("tbl%0d.flush_cnt", i), flush_cnt, tbl[i].flush);
         tick();
      end

      // Long data-memory freeze with hazard and jump pending
      do_reset("rst_a");
      set_in(1'b1, OP_J, OP_LW, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c <= 300; c++) begin
         if (c == 15) check("mw.stall_at15", stall_cnt, CMAX);
         if (c == 20) check("mw.stall_sat", stall_cnt, CMAX);
         if (c == 255) check("mw.tmo_before", mem_timeout, 0);
         if (c == 256) check("mw.tmo_at256", mem_timeout, 1);
         settle(1, "mw");
         tick();
      end
      check("mw.state", state, 2);
      set_in(1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         settle(1, "mw_exit");
         tick();
      end
      check("mw.tmo_sticky", mem_timeout, 1);
      check("mw.flush_cnt", flush_cnt, 0);
      check("mw.stall_hold", stall_cnt, CMAX);

      // Reset while in MEMWAIT
      set_in(1'b0, OP_NOP, OP_SW, 1'b1, 1'b0, 1'b0);
      settle(1, "mw2"); tick();
      settle(1, "mw2"); tick();
      check("mw2.state", state, 2);
      do_reset("rst_mw");
      set_in(1'b0, OP_NOP, OP_NOP, 1'b1, 1'b1, 1'b0);

      // Halt and drain
      settle(1, "pre_halt"); tick();
      halt_req = 1'b1;
      settle(1, "h0");
      check("h0.pc_we", pc_we, 0);
      check("h0.if_id_flush", if_id_flush, 1);
      tick();
      settle(1, "h1");
      check("h1.state", state, 3);
      check("h1.stall_cnt", stall_cnt, 1);
      tick();
      settle(1, "h2"); tick();
      settle(1, "h3");
      check("h3.halted", halted, 0);
      tick();
      settle(1, "h4");
      check("h4.halted", halted, 1);
      check("h4.pc_we", pc_we, 0);
      check("h4.stall_cnt", stall_cnt, 1);
      tick();
      halt_req = 1'b0;
      settle(1, "h_rel"); tick();
      settle(1, "h_run");
      check("h_run.state", state, 0);
      check("h_run.halted", halted, 0);
      tick();

      // Halt with a 4-cycle data freeze in the middle of the drain
      halt_req = 1'b1;
      settle(1, "f0"); tick();
      settle(1, "f1"); tick();
      opcode_step_4 = OP_LW; dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle(1, "frz");
         check("frz.ex_mem_we", ex_mem_we, 0);
         check("frz.state", state, 3);
         tick();
      end
      opcode_step_4 = OP_NOP; dmem_ready = 1'b1;
      settle(1, "f2");
      check("f2.halted", halted, 0);
      tick();
      settle(1, "f3");
      check("f3.halted", halted, 0);
      tick();
      settle(1, "f4");
      check("f4.halted", halted, 1);
      tick();

      // Reset while halted with halt_req still high
      do_reset("rst_halt");
      halt_req = 1'b0;

      // Randomized traffic against the model
      for (int chunk = 0; chunk < 25; chunk++) begin
         if (chunk != 0) do_reset("rst_rand");
         halt_req = 1'b0;
         for (int i = 0; i < 36; i++) begin
            int r;
            is_hazard  = ($urandom_range(0, 7) == 0);
            imem_ready = ($urandom_range(0, 7) != 0);
            dmem_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 3);
            opcode_step_4 = (r == 0) ? OP_LW : (r == 1) ? OP_SW : 6'($urandom);
            opcode_step_2 = ($urandom_range(0, 3) == 0) ? OP_J : 6'($urandom);
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            settle(1, "rand");
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Inputs: the registered hazard flag from the hazard unit, instruction/data memory ready handshakes, the jump opcode in stage 2, and a halt request.
- Outputs: per-stage write enables, bubble and flush controls, a halt-drain handshake and saturating performance counters.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.
- MEM_TIMEOUT, 255, consecutive MEMWAIT cycles before mem_timeout sets.
- DRAIN_CYC, 3, cycles of NOP injection after halt entry before halted asserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- is_hazard  in  1  data hazard between stage 2 and stages 3/4/5.
- opcode_step_2  in  6  opcode in decode; 6'b000010 = j.
- opcode_step_4  in  6  opcode in memory stage; 6'b100011 = lw, 6'b101011 = sw.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- dmem_ready  in  1  data memory completes access this cycle.
- halt_req  in  1  level request to stop fetch and drain.
- pc_we  out  1  PC register load enable.
- if_id_we  out  1  IF/ID register load enable.
- if_id_flush  out  1  load NOP into IF/ID; only meaningful when if_id_we=1.
- id_ex_bubble  out  1  load NOP into ID/EX.
- ex_mem_we  out  1  EX/MEM load enable.
- mem_wb_we  out  1  MEM/WB load enable.
- halted  out  1  drain complete; pipeline is empty.
- mem_timeout  out  1  sticky: a MEMWAIT run reached MEM_TIMEOUT.
- state  out  2  RUN=0, STALL=1, MEMWAIT=2, HALT=3.
- stall_cnt  out  CNT_W  cycles with pc_we=0 outside HALT; saturating.
- flush_cnt  out  CNT_W  jump flushes issued; saturating.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, drain counter=0, MEMWAIT counter=0, halted=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- Control outputs are combinational from the current state and inputs.
- Derived conditions:
  - memop = opcode_step_4 is lw or sw.
  - dfreeze = memop & !dmem_ready.
  - ifstall = !imem_ready.
  - jmp = (opcode_step_2 == 6'b000010).
- Default: every enable = 1, bubble = 0, flush = 0.
- Priority in RUN/STALL/MEMWAIT, first match wins:
  1. dfreeze: pc_we = if_id_we = ex_mem_we = mem_wb_we = 0; id_ex_bubble = 0 (whole pipe frozen). Next state MEMWAIT.
  2. is_hazard | ifstall: pc_we = if_id_we = 0; id_ex_bubble = 1. Next state STALL.
  3. jmp: if_id_flush = 1 (the instruction behind the jump is squashed; PC loads the target). flush_cnt += 1. Next state RUN.
  4. Otherwise: all enables 1. Next state RUN.
- halt_req is sampled only when none of rules 1-3 apply.
  - Sampled high: state→HALT, drain counter=0.
  - On that entry cycle, pc_we=0 and if_id_flush=1.
- HALT state:
  - pc_we = 0; if_id_we = 1 with if_id_flush = 1; id_ex_bubble = 0; ex_mem_we = mem_wb_we = 1.
  - dfreeze in HALT still forces all enables to 0; the drain counter holds, and state stays HALT (no MEMWAIT transition).
  - Drain counter increments each non-frozen cycle, saturating at DRAIN_CYC.
  - halted = (drain counter == DRAIN_CYC), registered.
  - halt_req low: next state RUN, halted cleared at that edge, drain counter=0.
  - is_hazard and jmp are ignored in HALT.
- MEMWAIT counter:
  - Increments each cycle state==MEMWAIT and dfreeze still holds, saturating at MEM_TIMEOUT.
  - Resets to 0 on any exit from MEMWAIT.
  - Reaching MEM_TIMEOUT sets mem_timeout; only rst clears it.
- stall_cnt: +1 on every cycle where pc_we=0 and state!=HALT (includes the halt-entry cycle). Holds at all-ones.
- flush_cnt: +1 per rule-3 cycle. Holds at all-ones.
- Simultaneous dfreeze + is_hazard + jmp: rule 1 only; no flush, no count on flush_cnt.
- Reset mid-MEMWAIT or mid-HALT: immediate return to RUN, with all outputs at their default/reset values.

Test Plan:
- Reset release with all ready=1, no hazard, opcodes 6'b001000: state=0; all enables 1; bubble/flush 0; counters stay 0 for 10 cycles.
- is_hazard=1 for 2 cycles: pc_we=if_id_we=0 and id_ex_bubble=1 both cycles; state=1; stall_cnt=2; RUN on the 3rd cycle.
- opcode_step_4=6'b100011, dmem_ready=0 for 300 cycles, is_hazard=1 and opcode_step_2=6'b000010 concurrently:
  - all enables 0, no bubble, no flush.
  - state=2; mem_timeout=1 from the 256th MEMWAIT cycle, still 1 after dmem_ready=1.
  - flush_cnt=0.
- opcode_step_2=6'b000010 for one cycle: if_id_flush=1, pc_we=1, flush_cnt=1.
- Same jump with imem_ready=0: stall instead; flush issues on the first cycle imem_ready=1.
- halt_req=1 in idle RUN:
  - state=3, pc_we=0, if_id_flush=1; halted=1 after 3 drain cycles.
  - dmem freeze mid-drain delays halted by the freeze length.
  - halt_req=0 → RUN, halted=0.
- Force stall_cnt to all-ones via 2^CNT_W stall cycles (CNT_W=4 build: 16): holds at 15. Assert rst mid-HALT: every output returns to its reset value without a clock edge.
